dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the DMA/loader.
- Sits between the requesters and the data memory. The memory has a 32-bit word address, a write path, and a combinational read path; it wraps at its word depth.
- Arbitration is round-robin with an optional lock, so one requester can hold the memory for multi-beat bursts.
- Each granted read returns registered data with a one-cycle valid pulse.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port indices, FSM state encoding and bus width defaults.
package dmem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic CPU = 1'b0;
  localparam logic DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with an ownership override.
// Produces a one-hot (or zero) grant vector.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       own_valid,
  input  logic       own_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    // An owner blocks the other port even when it is not requesting
    if (own_valid) begin
      if (own_id) gnt = {req[1], 1'b0};
      else        gnt = {1'b0, req[0]};
    end else if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst lock sharing one data memory
// between the CPU load/store unit (port 0) and the DMA (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t           state, state_n;
  logic             last, last_n;
  logic [CNT_W-1:0] lock_cnt, cnt_n;

  logic [1:0] gnt_raw;
  logic [1:0] gnt_v;
  logic       any_gnt;
  logic       gid;
  logic       sel_we;
  logic       sel_lock;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .last      (last),
    .own_valid (state != IDLE),
    .own_id    (state == OWN1),
    .gnt       (gnt_raw)
  );

  assign gnt_v   = reset ? 2'b00 : gnt_raw;
  assign gnt0    = gnt_v[0];
  assign gnt1    = gnt_v[1];
  assign any_gnt = |gnt_v;
  assign gid     = gnt_v[1];

  always_comb begin
    sel_we          = gid ? we1 : we0;
    sel_lock        = gid ? lock1 : lock0;
    mem_write_en    = any_gnt & sel_we;
    mem_read_en     = any_gnt & ~sel_we;
    mem_access_addr = '0;
    mem_in          = '0;
    if (any_gnt) begin
      mem_access_addr = gid ? addr1 : addr0;
      mem_in          = gid ? wdata1 : wdata0;
    end
  end

  // lock_cnt counts grants of the current locked session
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = lock_cnt;
    if (any_gnt) last_n = gid;
    unique case (state)
      IDLE: begin
        if (any_gnt && sel_lock && (LOCK_MAX > 1)) begin
          state_n = gid ? OWN1 : OWN0;
          cnt_n   = CNT_W'(1);
        end
      end
      OWN0, OWN1: begin
        if (any_gnt) begin
          if (!sel_lock || lock_cnt == CNT_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = lock_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= DMA;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      lock_cnt <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt_v[0] & ~we0;
      rvalid1 <= gnt_v[1] & ~we1;
      if (gnt_v[0] & ~we0) rdata0 <= mem_out;
      if (gnt_v[1] & ~we1) rdata1 <= mem_out;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter against a
// transaction-level model of grants, locks and memory.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LM    = 4;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_in, mem_out;
  logic          mem_write_en, mem_read_en;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_access_addr(mem_access_addr), .mem_in(mem_in),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_out(mem_out)
  );

  // memory device: wraps at DEPTH words
  logic [DW-1:0] mem [DEPTH];
  assign mem_out = mem[mem_access_addr[5:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[5:0]] <= mem_in;

  int checks = 0;
  int errors = 0;

  // reference model
  int            owner;
  int            last_p;
  int            burst;
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] ref_mem [DEPTH];
  int            last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner     = -1;
    last_p    = 1;
    burst     = 0;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic cyc(
    input logic r0, input logic w0, input logic l0,
    input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic l1,
    input logic [31:0] a1, input logic [31:0] d1);
    int          g;
    logic        rr [2];
    logic        ww [2];
    logic        ll [2];
    logic [31:0] aa [2];
    logic [31:0] dd [2];
    rr[0] = r0; ww[0] = w0; ll[0] = l0; aa[0] = a0; dd[0] = d0;
    rr[1] = r1; ww[1] = w1; ll[1] = l1; aa[1] = a1; dd[1] = d1;
    @(negedge clk);
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, exp_rv[0]});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, exp_rv[1]});
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    g = -1;
    if (owner >= 0) begin
      if (rr[owner]) g = owner;
    end else if (r0 && r1) g = 1 - last_p;
    else if (r0) g = 0;
    else if (r1) g = 1;
    chk("gnt", {30'b0, gnt1, gnt0}, (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
    if (g < 0) begin
      chk("idle_we", {31'b0, mem_write_en}, 32'd0);
      chk("idle_re", {31'b0, mem_read_en}, 32'd0);
      chk("idle_addr", mem_access_addr, 32'd0);
      chk("idle_din", mem_in, 32'd0);
    end else begin
      chk("mem_we", {31'b0, mem_write_en}, {31'b0, ww[g]});
      chk("mem_re", {31'b0, mem_read_en}, {31'b0, ~ww[g]});
      chk("mem_addr", mem_access_addr, aa[g]);
      chk("mem_din", mem_in, dd[g]);
    end
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (g >= 0) begin
      if (ww[g]) ref_mem[aa[g] % DEPTH] = dd[g];
      else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[aa[g] % DEPTH];
      end
      last_p = g;
      if (owner < 0) begin
        if (ll[g]) begin owner = g; burst = 1; end
      end else begin
        burst++;
        if (!ll[g] || burst == LM) owner = -1;
      end
    end
    last_g = g;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    chk("rst_en", {30'b0, mem_write_en, mem_read_en}, 32'd0);
    chk("rst_rv", {30'b0, rvalid1, rvalid0}, 32'd0);
    chk("rst_rd0", rdata0, 32'd0);
    chk("rst_rd1", rdata1, 32'd0);
    req0 = 1'b0;
    reset = 1'b0;

    // load memory through the DMA port
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 0, 0, 0, 0, 1, 1, 0, i, (i == 3) ? 32'hA5A5A5A5 : $urandom);

    // single read, port 0 wins after a fresh reset-equivalent last
    cyc(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("rd3_gnt", {30'b0, gnt1, gnt0}, 32'd1);
    idle();
    chk("rd3_data", rdata0, 32'hA5A5A5A5);
    chk("rd3_rv1", {31'b0, rvalid1}, 32'd0);

    // contention alternates
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 10 + i, 0, 1, 0, 0, 20 + i, 0);
      chk("alt", {30'b0, gnt1, gnt0}, (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    idle();

    // read-after-write across ports
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 5, 32'hDEADBEEF);
    cyc(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    idle();
    chk("raw_data", rdata0, 32'hDEADBEEF);

    // locked burst of 4 writes, lock dropped on the last
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 40, 0, 1, 1, (i < 3), 30 + i, $urandom);
      chk("burst", {30'b0, gnt1, gnt0}, 32'd2);
    end
    cyc(1, 0, 0, 40, 0, 0, 0, 0, 0, 0);
    chk("burst_end", {30'b0, gnt1, gnt0}, 32'd1);

    // lock held forever: forced release after LM grants
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 41, 0, 1, 1, 1, 50 + i, $urandom);
      chk("force", {30'b0, gnt1, gnt0}, (i < 4) ? 32'd2 : 32'd1);
    end

    // reset while port 1 owns with a read in flight
    cyc(1, 0, 0, 42, 0, 1, 0, 1, 3, 0);
    chk("own_rd", {30'b0, gnt1, gnt0}, 32'd2);
    @(posedge clk);
    #1;
    chk("own_rv1", {31'b0, rvalid1}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rv1", {31'b0, rvalid1}, 32'd0);
    chk("mid_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 0, 3, 0, 1, 0, 0, 4, 0);
    chk("post_rst", {30'b0, gnt1, gnt0}, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom % 2), $urandom_range(0, 3) == 0,
          $urandom, $urandom,
          $urandom_range(0, 3) != 0, 1'($urandom % 2), $urandom_range(0, 3) == 0,
          $urandom, $urandom);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
